demorgan_frame_decoder: RTL and testbench

//   Receive-side decoder for frames of polarity-encoded words. Each word arrives with the

---
 rtl/demorgan_frame_decoder_if.sv | 30 +++
 rtl/demorgan_frame_decoder.sv | 129 ++++++++++++
 tb/tb_demorgan_frame_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/demorgan_frame_decoder_if.sv
// Word stream in and per-frame result out for the polarity frame decoder.
// The decoder connects through the slave modport; the producer/consumer side uses master.
interface demorgan_frame_decoder_if #(
   parameter int unsigned W     = 3,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             in_par;
   logic             out_valid;
   logic             out_ready;
   logic             out_and;
   logic             out_or;
   logic             out_xor;
   logic [CNT_W-1:0] out_cnt;
   logic             out_err;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_last, in_par, out_ready,
      input  in_ready, out_valid, out_and, out_or, out_xor, out_cnt, out_err, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, in_par, out_ready,
      output in_ready, out_valid, out_and, out_or, out_xor, out_cnt, out_err, out_ovf
   );
endinterface

// File: rtl/demorgan_frame_decoder.sv
// Strips the encoder's polarity inversion and reduces every decoded bit of a frame
// to AND/OR/XOR, with a saturating word count and a frame parity check.
module demorgan_frame_decoder #(
   parameter int unsigned    W        = 3,
   parameter logic [W-1:0]   INV_MASK = 3'b101,
   parameter int unsigned    CNT_W    = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   demorgan_frame_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t state, state_next;

   logic [W-1:0]     d;
   logic             in_ready;
   logic             accept;
   logic             start;

   logic             acc_and, acc_or, acc_xor, acc_ovf;
   logic [CNT_W-1:0] acc_cnt;
   logic             n_and, n_or, n_xor, n_ovf;
   logic [CNT_W-1:0] n_cnt;

   logic             out_valid;
   logic             out_and, out_or, out_xor, out_err, out_ovf;
   logic [CNT_W-1:0] out_cnt;

   assign d        = bus.in_data ^ INV_MASK;
   assign in_ready = (state != HOLD) || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   // An accept in HOLD only happens once the result is consumed, so it opens a new frame.
   assign start    = accept && (state != ACC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      n_and      = acc_and;
      n_or       = acc_or;
      n_xor      = acc_xor;
      n_cnt      = acc_cnt;
      n_ovf      = acc_ovf;

      if (start) begin
         n_and = &d;
         n_or  = |d;
         n_xor = ^d;
         n_cnt = CNT_ONE;
         n_ovf = 1'b0;
      end else begin
         n_and = acc_and & (&d);
         n_or  = acc_or  | (|d);
         n_xor = acc_xor ^ (^d);
         if (acc_cnt == CNT_MAX) begin
            n_ovf = 1'b1;
         end else begin
            n_cnt = acc_cnt + CNT_ONE;
         end
      end

      if (accept) begin
         state_next = bus.in_last ? HOLD : ACC;
      end else if (state == HOLD && bus.out_ready) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_and   <= 1'b0;
         acc_or    <= 1'b0;
         acc_xor   <= 1'b0;
         acc_cnt   <= '0;
         acc_ovf   <= 1'b0;
         out_valid <= 1'b0;
         out_and   <= 1'b0;
         out_or    <= 1'b0;
         out_xor   <= 1'b0;
         out_cnt   <= '0;
         out_err   <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         if (accept) begin
            acc_and <= n_and;
            acc_or  <= n_or;
            acc_xor <= n_xor;
            acc_cnt <= n_cnt;
            acc_ovf <= n_ovf;
         end
         if (accept && bus.in_last) begin
            out_valid <= 1'b1;
            out_and   <= n_and;
            out_or    <= n_or;
            out_xor   <= n_xor;
            out_cnt   <= n_cnt;
            out_err   <= n_xor ^ bus.in_par;
            out_ovf   <= n_ovf;
         end else if (state == HOLD && bus.out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_and   = out_and;
   assign bus.out_or    = out_or;
   assign bus.out_xor   = out_xor;
   assign bus.out_cnt   = out_cnt;
   assign bus.out_err   = out_err;
   assign bus.out_ovf   = out_ovf;

endmodule

// File: tb/tb_demorgan_frame_decoder.sv
// Directed vectors for the frame decoder: a frame table plus hand-written
// backpressure, counter-saturation and mid-frame reset sequences.
module tb_demorgan_frame_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demorgan_frame_decoder_if #(.W(3), .CNT_W(8)) bus ();
   demorgan_frame_decoder_if #(.W(3), .CNT_W(2)) bus2 ();

   demorgan_frame_decoder #(.W(3), .INV_MASK(3'b101), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   demorgan_frame_decoder #(.W(3), .INV_MASK(3'b101), .CNT_W(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   typedef struct {
      int unsigned     n;
      logic [4:0][2:0] w;
      logic            par;
      logic            e_and;
      logic            e_or;
      logic            e_xor;
      logic [7:0]      e_cnt;
      logic            e_err;
   } vec_t;

   int unsigned total = 0;
   int unsigned passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic send_word(input logic [2:0] data, input logic last, input logic par);
      int unsigned k;
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_last  = last;
      bus.in_par   = par;
      k = 0;
      while (!bus.in_ready && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!bus.in_ready) check("ready_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic e_and, input logic e_or,
                               input logic e_xor, input logic [7:0] e_cnt, input logic e_err,
                               input logic e_ovf);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_and"},   32'(bus.out_and),   32'(e_and));
      check({tag, "_or"},    32'(bus.out_or),    32'(e_or));
      check({tag, "_xor"},   32'(bus.out_xor),   32'(e_xor));
      check({tag, "_cnt"},   32'(bus.out_cnt),   32'(e_cnt));
      check({tag, "_err"},   32'(bus.out_err),   32'(e_err));
      check({tag, "_ovf"},   32'(bus.out_ovf),   32'(e_ovf));
   endtask

   vec_t vecs[6];

   initial begin
      // 3-word frame first so the single-word frame after it reloads HOLD with zero bubble.
      vecs[0] = '{n: 3, w: {3'b000, 3'b000, 3'b010, 3'b010, 3'b010}, par: 1'b1,
                  e_and: 1'b1, e_or: 1'b1, e_xor: 1'b1, e_cnt: 8'd3, e_err: 1'b0};
      vecs[1] = '{n: 1, w: {3'b000, 3'b000, 3'b000, 3'b000, 3'b101}, par: 1'b0,
                  e_and: 1'b0, e_or: 1'b0, e_xor: 1'b0, e_cnt: 8'd1, e_err: 1'b0};
      vecs[2] = '{n: 2, w: {3'b000, 3'b000, 3'b000, 3'b111, 3'b101}, par: 1'b1,
                  e_and: 1'b0, e_or: 1'b1, e_xor: 1'b1, e_cnt: 8'd2, e_err: 1'b0};
      vecs[3] = '{n: 2, w: {3'b000, 3'b000, 3'b000, 3'b111, 3'b101}, par: 1'b0,
                  e_and: 1'b0, e_or: 1'b1, e_xor: 1'b1, e_cnt: 8'd2, e_err: 1'b1};
      vecs[4] = '{n: 2, w: {3'b000, 3'b000, 3'b000, 3'b010, 3'b000}, par: 1'b1,
                  e_and: 1'b0, e_or: 1'b1, e_xor: 1'b1, e_cnt: 8'd2, e_err: 1'b0};
      vecs[5] = '{n: 4, w: {3'b000, 3'b111, 3'b111, 3'b111, 3'b111}, par: 1'b0,
                  e_and: 1'b0, e_or: 1'b1, e_xor: 1'b0, e_cnt: 8'd4, e_err: 1'b0};

      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.in_par     = 1'b0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.in_last   = 1'b0;
      bus2.in_par    = 1'b0;
      bus2.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_cnt",   32'(bus.out_cnt),   32'd0);
      check("rst_ready", 32'(bus.in_ready),  32'd1);
      check("rst_and",   32'(bus.out_and),   32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_valid", 32'(bus.out_valid), 32'd0);

      // Frame table, back to back with out_ready held high
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < int'(vecs[i].n); j++) begin
            send_word(vecs[i].w[j], (j == int'(vecs[i].n) - 1), vecs[i].par);
            if (j != int'(vecs[i].n) - 1) check($sformatf("v%0d_w%0d_novalid", i, j),
                                               32'(bus.out_valid), 32'd0);
         end
         check_result($sformatf("v%0d", i), vecs[i].e_and, vecs[i].e_or, vecs[i].e_xor,
                      vecs[i].e_cnt, vecs[i].e_err, 1'b0);
      end
      @(posedge clk);
      #1;
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: result held under out_ready=0, then zero-bubble single-word frame
      send_word(3'b101, 1'b0, 1'b1);
      bus.out_ready = 1'b0;
      send_word(3'b111, 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 3'b111;
      bus.in_last  = 1'b1;
      bus.in_par   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("hold%0d_cnt", c),   32'(bus.out_cnt),   32'd2);
         check($sformatf("hold%0d_xor", c),   32'(bus.out_xor),   32'd1);
         check($sformatf("hold%0d_or", c),    32'(bus.out_or),    32'd1);
         check($sformatf("hold%0d_ready", c), 32'(bus.in_ready),  32'd0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_result("reload", 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reload_drop", 32'(bus.out_valid), 32'd0);

      // Saturating counter on the CNT_W=2 instance: 5 words of d=111
      bus2.in_data = 3'b010;
      bus2.in_par  = 1'b1;
      bus2.in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         bus2.in_last = (j == 4);
         @(posedge clk);
         #1;
      end
      bus2.in_valid = 1'b0;
      check("sat_valid", 32'(bus2.out_valid), 32'd1);
      check("sat_cnt",   32'(bus2.out_cnt),   32'd3);
      check("sat_ovf",   32'(bus2.out_ovf),   32'd1);
      check("sat_xor",   32'(bus2.out_xor),   32'd1);
      check("sat_err",   32'(bus2.out_err),   32'd0);
      check("sat_and",   32'(bus2.out_and),   32'd1);

      // Mid-frame reset: out_cnt still holds 1 from the previous frame
      send_word(3'b010, 1'b0, 1'b1);
      send_word(3'b010, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_cnt",   32'(bus.out_cnt),   32'd0);
      check("mrst_or",    32'(bus.out_or),    32'd0);
      check("mrst_xor",   32'(bus.out_xor),   32'd0);
      check("mrst_ready", 32'(bus.in_ready),  32'd1);
      check("mrst_sat_ovf", 32'(bus2.out_ovf), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("post_rst_novalid", 32'(bus.out_valid), 32'd0);
      end
      send_word(3'b010, 1'b1, 1'b1);
      check_result("post_rst", 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
